div_scheduler: RTL and testbench
================================

DIV_SCHEDULER -- requirements
Module: div_scheduler

Interface
REQ-001 SHALL have parameter DATA_W, default 12, the operand/result width in 12-bit float format (1 sign, 5 exponent, 6 mantissa).
REQ-002 SHALL have parameter RR_INIT, default 0, the requester holding priority after reset.
REQ-003 SHALL have one clock, clk (input, 1), with all state updating on its rising edge.
REQ-004 SHALL have reset rst_n (input, 1), asynchronous and active-low.
REQ-005 SHALL have, per requester k in {0,1}: reqk_valid (input, 1); reqk_ready (output, 1); reqk_a (input, DATA_W) dividend; reqk_b (input, DATA_W) divisor.
REQ-006 SHALL have, per requester k: respk_valid (output, 1); respk_ready (input, 1); respk_data (output, DATA_W) quotient.
REQ-007 SHALL have divider-side ports: div_a and div_b (output, DATA_W) operands; div_start (output, 1); div_done (input, 1); div_result (input, DATA_W).

Function
REQ-008 SHALL implement the FSM IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
REQ-009 In IDLE, when any reqk_valid is high, it SHALL grant one requester, assert that reqk_ready for exactly one cycle, latch a/b and the grant id, and go to ISSUE.
REQ-010 Arbitration SHALL be round-robin: on simultaneous requests the non-last-granted requester wins; a lone request always wins.
REQ-011 In ISSUE, it SHALL drive div_a/div_b from the latched operands and pulse div_start high for one cycle, then go to WAIT.
REQ-012 div_a/div_b SHALL stay stable from ISSUE until WAIT exits.
REQ-013 In WAIT, it SHALL capture div_result on the first cycle div_done is high and go to RESP; the minimum request-to-response latency is 3 cycles.
REQ-014 In RESP, it SHALL assert only the granted respk_valid with respk_data held stable until respk_ready is high, then go to IDLE and update the round-robin pointer.
REQ-015 reqk_ready SHALL be low in every state except the IDLE grant cycle, so only one operation is outstanding at a time.
REQ-016 A div_done seen outside WAIT SHALL be ignored.
REQ-017 A requester deasserting valid before its grant SHALL lose nothing; the scheduler SHALL NOT latch an ungranted request.

Reset
REQ-018 While rst_n is low, the block SHALL hold state IDLE with all ready/valid/div_start outputs 0, div_a/div_b/respk_data 0, and round-robin pointer RR_INIT.
REQ-019 Reset asserted mid-operation SHALL abandon the operation with no response; any later div_done SHALL be ignored per REQ-016.

Configuration
REQ-020 With DIV_SCHED_ZERO_BYPASS_EN defined, a latched divisor whose exponent and mantissa are both 0 SHALL skip ISSUE/WAIT and go straight to RESP with sign = a.sign XOR b.sign, exponent 5'h1F and mantissa 0 (infinity); div_start SHALL NOT pulse.
REQ-021 Without DIV_SCHED_ZERO_BYPASS_EN, zero divisors SHALL be issued to the divider like any other operand.

Structure
REQ-022 A shared package div_pkg SHALL hold DATA_W-derived field widths (SIGN_BIT, EXP_W=5, MAN_W=6), the state enum, and the infinity-construction constants.
REQ-023 Round-robin arbitration SHALL be a sub-module div_rr_arb (2 requests, grant one-hot, pointer update on an accept pulse).

Verification
REQ-024 A single request on req0 with a=12'hC78, b=12'h460, where the model divider raises div_done 2 cycles after div_start, SHALL give exactly one div_start, resp0_valid with model quotient, and resp1_valid never high.
REQ-025 req0 and req1 valid in the same cycle from reset with RR_INIT=0 SHALL serve req0 first, then req1; a repeat of both SHALL serve req0 then req1 again, alternating.
REQ-026 resp0_ready held low 5 cycles SHALL keep resp0_valid/resp0_data stable and both req*_ready low throughout.
REQ-027 rst_n pulsed low during WAIT, followed by a late div_done, SHALL produce no response, and the next request SHALL complete normally.
REQ-028 b=12'h000 with a=12'h800: with DIV_SCHED_ZERO_BYPASS_EN, resp data=12'hFC0 and no div_start; without it, div_start pulses once.
REQ-029 A spurious div_done in IDLE or RESP SHALL cause no state change or response.

Source files
------------

// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - float12 field widths, scheduler FSM states and infinity constants
package div_pkg;

  localparam int DATA_W_DFLT = 12;
  localparam int SIGN_BIT    = DATA_W_DFLT - 1;
  localparam int EXP_W       = 5;
  localparam int MAN_W       = 6;

  localparam logic [EXP_W-1:0] INF_EXP = 5'h1F;
  localparam logic [MAN_W-1:0] INF_MAN = 6'h00;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  function automatic logic [SIGN_BIT:0] make_inf(input logic sign);
    return {sign, INF_EXP, INF_MAN};
  endfunction

  // Exponent and mantissa both zero, sign ignored: +0 and -0 alike.
  function automatic logic is_zero_mag(input logic [SIGN_BIT:0] v);
    return (v[EXP_W+MAN_W-1:0] == '0);
  endfunction

endpackage

// File: rtl/div_rr_arb.sv
// rtl/div_rr_arb.sv - two-requester round-robin arbiter, one-hot grant, priority moves on accept
module div_rr_arb #(
  parameter int RR_INIT = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req_i,
  input  logic       accept_i,
  input  logic       accept_id_i,
  output logic [1:0] gnt_o
);

  logic prio_q;

  always_comb begin
    gnt_o = req_i;
    if (req_i == 2'b11) begin
      gnt_o = prio_q ? 2'b10 : 2'b01;
    end
  end

  // Priority passes to whichever requester was not just served.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_q <= (RR_INIT != 0);
    end else if (accept_i) begin
      prio_q <= ~accept_id_i;
    end
  end

endmodule

// File: rtl/div_scheduler.sv
// rtl/div_scheduler.sv - shares one external divider between two requesters, one op in flight
// Optional zero-divisor bypass to infinity enabled by DIV_SCHED_ZERO_BYPASS_EN.
module div_scheduler
  import div_pkg::*;
#(
  parameter int DATA_W  = 12,
  parameter int RR_INIT = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  output logic              resp0_valid,
  input  logic              resp0_ready,
  output logic [DATA_W-1:0] resp0_data,
  output logic              resp1_valid,
  input  logic              resp1_ready,
  output logic [DATA_W-1:0] resp1_data,
  output logic [DATA_W-1:0] div_a,
  output logic [DATA_W-1:0] div_b,
  output logic              div_start,
  input  logic              div_done,
  input  logic [DATA_W-1:0] div_result
);

  state_e            state_q;
  logic [DATA_W-1:0] a_q, b_q, resp_data_q;
  logic              gnt_id_q;
  logic              div_start_q;
  logic [1:0]        resp_valid_q;

  logic [1:0]        gnt;
  logic              accept;
  logic [DATA_W-1:0] sel_a_d, sel_b_d;

  div_rr_arb #(.RR_INIT(RR_INIT)) u_arb (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_i      ({req1_valid, req0_valid}),
    .accept_i   (accept),
    .accept_id_i(gnt_id_q),
    .gnt_o      (gnt)
  );

  assign accept  = (state_q == ST_RESP) && (gnt_id_q ? resp1_ready : resp0_ready);
  assign sel_a_d = gnt[1] ? req1_a : req0_a;
  assign sel_b_d = gnt[1] ? req1_b : req0_b;

  // Ready only in IDLE and only toward the granted requester, so nothing ungranted is latched.
  assign req0_ready  = (state_q == ST_IDLE) && gnt[0];
  assign req1_ready  = (state_q == ST_IDLE) && gnt[1];
  assign div_a       = a_q;
  assign div_b       = b_q;
  assign div_start   = div_start_q;
  assign resp0_valid = resp_valid_q[0];
  assign resp1_valid = resp_valid_q[1];
  assign resp0_data  = resp_data_q;
  assign resp1_data  = resp_data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      a_q          <= '0;
      b_q          <= '0;
      gnt_id_q     <= 1'b0;
      div_start_q  <= 1'b0;
      resp_valid_q <= 2'b00;
      resp_data_q  <= '0;
    end else begin
      div_start_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (|gnt) begin
            a_q      <= sel_a_d;
            b_q      <= sel_b_d;
            gnt_id_q <= gnt[1];
`ifdef DIV_SCHED_ZERO_BYPASS_EN
            if (is_zero_mag(sel_b_d)) begin
              resp_data_q  <= make_inf(sel_a_d[SIGN_BIT] ^ sel_b_d[SIGN_BIT]);
              resp_valid_q <= gnt;
              state_q      <= ST_RESP;
            end else begin
              div_start_q <= 1'b1;
              state_q     <= ST_ISSUE;
            end
`else
            div_start_q <= 1'b1;
            state_q     <= ST_ISSUE;
`endif
          end
        end
        ST_ISSUE: begin
          state_q <= ST_WAIT;
        end
        ST_WAIT: begin
          if (div_done) begin
            resp_data_q  <= div_result;
            resp_valid_q <= gnt_id_q ? 2'b10 : 2'b01;
            state_q      <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (accept) begin
            resp_valid_q <= 2'b00;
            state_q      <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_scheduler.sv
// tb/tb_div_scheduler.sv - directed bench for div_scheduler with float12 divider model and scoreboard
module tb_div_scheduler;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [11:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic        resp0_valid, resp1_valid;
  logic        resp0_ready = 1'b1, resp1_ready = 1'b1;
  logic [11:0] resp0_data, resp1_data;
  logic [11:0] div_a, div_b, div_result = '0;
  logic        div_start;
  logic        div_done = 1'b0;

  div_scheduler #(.DATA_W(12), .RR_INIT(0)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .resp0_valid(resp0_valid), .resp0_ready(resp0_ready), .resp0_data(resp0_data),
    .resp1_valid(resp1_valid), .resp1_ready(resp1_ready), .resp1_data(resp1_data),
    .div_a(div_a), .div_b(div_b), .div_start(div_start),
    .div_done(div_done), .div_result(div_result)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  int cyc = 0;
  int n_start = 0, n_resp0 = 0, n_resp1 = 0;
  int spur_cnt = 0, spur_seen = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Real float12 division (1/5/6, bias 15) for normal operands; zero divisor gives signed infinity.
  function automatic logic [11:0] fdiv(input logic [11:0] a, input logic [11:0] b);
    int ea, eb, ma, mb, m, e;
    if (b[10:0] == 11'd0) return {a[11] ^ b[11], 5'h1F, 6'h00};
    ea = int'(a[10:6]); eb = int'(b[10:6]);
    ma = 64 + int'(a[5:0]); mb = 64 + int'(b[5:0]);
    if (ma >= mb) begin m = (ma * 64) / mb;  e = ea - eb + 15; end
    else          begin m = (ma * 128) / mb; e = ea - eb + 14; end
    return {a[11] ^ b[11], 5'(e), 6'(m - 64)};
  endfunction

  typedef struct {
    bit          id;
    logic [11:0] a;
    logic [11:0] b;
  } op_t;

  op_t         sb[$];
  int          dv_cnt = 0;
  logic [11:0] dv_a = '0, dv_b = '0;
  bit          held0 = 0, held1 = 0;
  logic [11:0] held_data = '0;

  // Model + compare at negedge, then advance the divider model (done 2 cycles after start).
  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
      held0 = 0; held1 = 0;
      chk("reset_outputs",
          {req0_ready, req1_ready, resp0_valid, resp1_valid, div_start, div_a, div_b, resp0_data, resp1_data},
          '0);
    end else begin
      chk("ready_onehot", 32'(req0_ready & req1_ready), 0);
      chk("ready0_without_valid", 32'(req0_ready & ~req0_valid), 0);
      chk("ready1_without_valid", 32'(req1_ready & ~req1_valid), 0);
      chk("ready_while_outstanding", 32'((req0_ready | req1_ready) && sb.size() != 0), 0);
      chk("resp_both_valid", 32'(resp0_valid & resp1_valid), 0);
      if (held0) chk("resp0_hold_valid", 32'(resp0_valid), 1);
      if (held1) chk("resp1_hold_valid", 32'(resp1_valid), 1);
      if (held0 || held1) chk("resp_hold_data", held0 ? resp0_data : resp1_data, held_data);
      if (div_start) begin
        n_start++;
        chk("start_with_op", 32'(sb.size() != 0), 1);
        if (sb.size() != 0) begin
          chk("div_a_at_start", div_a, sb[0].a);
          chk("div_b_at_start", div_b, sb[0].b);
`ifdef DIV_SCHED_ZERO_BYPASS_EN
          chk("start_on_zero_divisor", 32'(sb[0].b[10:0] == 11'd0), 0);
`endif
        end
      end
      if (dv_cnt > 0 && sb.size() != 0) begin
        chk("div_a_stable", div_a, dv_a);
        chk("div_b_stable", div_b, dv_b);
      end
      if (resp0_valid || resp1_valid) begin
        chk("resp_expected", 32'(sb.size() != 0), 1);
        if (sb.size() != 0) begin
          chk("resp_id", 32'(resp1_valid), 32'(sb[0].id));
          chk("resp_data", resp1_valid ? resp1_data : resp0_data, fdiv(sb[0].a, sb[0].b));
        end
      end
      if (resp0_valid) n_resp0++;
      if (resp1_valid) n_resp1++;
      held0 = resp0_valid && !resp0_ready;
      held1 = resp1_valid && !resp1_ready;
      held_data = resp0_valid ? resp0_data : resp1_data;
      if ((resp0_valid && resp0_ready) || (resp1_valid && resp1_ready)) begin
        if (sb.size() != 0) void'(sb.pop_front());
      end
      if (req0_valid && req0_ready) sb.push_back('{id: 1'b0, a: req0_a, b: req0_b});
      if (req1_valid && req1_ready) sb.push_back('{id: 1'b1, a: req1_a, b: req1_b});
    end
    // Divider model is never reset: a reset mid-operation leaves a late done in flight.
    div_done = 1'b0;
    if (dv_cnt > 0) begin
      dv_cnt--;
      if (dv_cnt == 0) begin
        div_done   = 1'b1;
        div_result = fdiv(dv_a, dv_b);
      end
    end
    if (spur_cnt != spur_seen) begin
      spur_seen  = spur_cnt;
      div_done   = 1'b1;
      div_result = 12'hEEE;
    end
    if (div_start && rst_n) begin
      dv_cnt = 2; dv_a = div_a; dv_b = div_b;
    end
  end

  task automatic set_req(input int k, input logic v, input logic [11:0] a, input logic [11:0] b);
    if (k == 0) begin req0_valid = v; req0_a = a; req0_b = b; end
    else        begin req1_valid = v; req1_a = a; req1_b = b; end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin @(posedge clk); #1; end
  endtask

  // Wait for requester k's grant; drop its valid after the grant edge.
  task automatic wait_grant(input int k, output int gcyc);
    bit got = 0;
    gcyc = -1;
    for (int n = 0; n < 60 && !got; n++) begin
      @(negedge clk);
      got = (k == 0) ? req0_ready : req1_ready;
      if (got) gcyc = cyc;
      @(posedge clk); #1;
    end
    set_req(k, 1'b0, 12'h000, 12'h000);
    chk("grant_timeout", 32'(got), 1);
  endtask

  task automatic issue(input int k, input logic [11:0] a, input logic [11:0] b, output int gcyc);
    set_req(k, 1'b1, a, b);
    wait_grant(k, gcyc);
  endtask

  task automatic wait_resp(input int k, output logic [11:0] d, output int rcyc);
    bit got = 0;
    d = 'x; rcyc = -1;
    for (int n = 0; n < 60 && !got; n++) begin
      @(negedge clk);
      got = (k == 0) ? resp0_valid : resp1_valid;
      if (got) begin d = (k == 0) ? resp0_data : resp1_data; rcyc = cyc; end
      @(posedge clk); #1;
    end
    chk("resp_timeout", 32'(got), 1);
  endtask

  task automatic both(input logic [11:0] a0, input logic [11:0] b0, input logic [11:0] a1,
                      input logic [11:0] b1, output int first, output int second);
    int order[2];
    int cnt = 0;
    bit d0, d1;
    bit g0 = 0, g1 = 0;
    order[0] = -1; order[1] = -1;
    set_req(0, 1'b1, a0, b0);
    set_req(1, 1'b1, a1, b1);
    for (int n = 0; n < 100 && !(g0 && g1); n++) begin
      @(negedge clk);
      d0 = req0_ready; d1 = req1_ready;
      if (d0 && cnt < 2) begin order[cnt] = 0; cnt++; end
      if (d1 && cnt < 2) begin order[cnt] = 1; cnt++; end
      @(posedge clk); #1;
      if (d0) begin set_req(0, 1'b0, 12'h000, 12'h000); g0 = 1; end
      if (d1) begin set_req(1, 1'b0, 12'h000, 12'h000); g1 = 1; end
    end
    chk("both_granted", 32'(g0 && g1), 1);
    first = order[0]; second = order[1];
  endtask

  initial begin
    int f, s, gc, rc, st0, r1c, r0c;
    logic [11:0] d;

    // Reset, with a request pending that must not be acknowledged.
    req0_valid = 1'b1; req0_a = 12'h3C0; req0_b = 12'h400;
    step(3);
    req0_valid = 1'b0;
    step(1);
    rst_n = 1'b1;
    step(2);

    // Pin the divider model to hand-computed quotients.
    chk("model_neg7p5_div_6", fdiv(12'hC78, 12'h460), 12'hBD0);
    chk("model_1_div_2", fdiv(12'h3C0, 12'h400), 12'h380);
    chk("model_6_div_3", fdiv(12'h460, 12'h420), 12'h400);
    chk("model_zero_div", fdiv(12'h800, 12'h000), 12'hFC0);

    // Simultaneous requests from reset: req0, then req1; repeat alternates the same way.
    both(12'h3C0, 12'h400, 12'h460, 12'h420, f, s);
    chk("rr_first_round_a", f, 0);
    chk("rr_first_round_b", s, 1);
    step(8);
    both(12'h460, 12'h420, 12'h3C0, 12'h400, f, s);
    chk("rr_second_round_a", f, 0);
    chk("rr_second_round_b", s, 1);
    step(8);

    // Single request on req0, 2-cycle divider.
    st0 = n_start; r1c = n_resp1;
    issue(0, 12'hC78, 12'h460, gc);
    wait_resp(0, d, rc);
    chk("single_quotient", d, 12'hBD0);
    chk("single_latency", rc - gc, 4);
    step(4);
    chk("single_start_count", n_start - st0, 1);
    chk("single_no_resp1", n_resp1 - r1c, 0);

    // req0 served last: simultaneous requests now favour req1.
    both(12'h3C0, 12'h400, 12'h460, 12'h420, f, s);
    chk("rr_after_req0_a", f, 1);
    chk("rr_after_req0_b", s, 0);
    step(8);

    // Back-pressure on resp0 with req1 waiting, plus a spurious done during RESP.
    resp0_ready = 1'b0;
    issue(0, 12'h3C0, 12'h400, gc);
    set_req(1, 1'b1, 12'h460, 12'h420);
    wait_resp(0, d, rc);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_valid", 32'(resp0_valid), 1);
      chk("hold_data", resp0_data, 12'h380);
      chk("hold_ready_low", 32'(req0_ready | req1_ready), 0);
      @(posedge clk); #1;
      if (i == 1) spur_cnt++;
    end
    resp0_ready = 1'b1;
    wait_grant(1, gc);
    wait_resp(1, d, rc);
    chk("after_hold_req1", d, 12'h400);
    step(4);

    // Spurious done in IDLE.
    st0 = n_start; r0c = n_resp0; r1c = n_resp1;
    spur_cnt++;
    step(6);
    chk("spur_idle_resp", (n_resp0 - r0c) + (n_resp1 - r1c), 0);
    chk("spur_idle_start", n_start - st0, 0);

    // Reset during WAIT, late done afterwards, then a normal request.
    issue(0, 12'hC78, 12'h460, gc);
    @(negedge clk);
    chk("reset_test_started", 32'(div_start), 1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    r0c = n_resp0; r1c = n_resp1;
    step(8);
    chk("reset_no_resp", (n_resp0 - r0c) + (n_resp1 - r1c), 0);
    issue(1, 12'h460, 12'h420, gc);
    wait_resp(1, d, rc);
    chk("post_reset_resp", d, 12'h400);
    step(4);

    // Zero divisor.
    st0 = n_start;
    issue(0, 12'h800, 12'h000, gc);
    wait_resp(0, d, rc);
    chk("zero_div_data", d, 12'hFC0);
    step(4);
`ifdef DIV_SCHED_ZERO_BYPASS_EN
    chk("zero_div_starts", n_start - st0, 0);
`else
    chk("zero_div_starts", n_start - st0, 1);
`endif

    step(4);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
